hazard_ctrl: RTL and testbench

// - Pipeline sequencer for the 5-stage RV32 core. Generates stall, flush and bubble controls around the forwarding network.
// - Covers hazards forwarding cannot resolve: load-use, multi-cycle multiply occupancy, data-memory wait and EX-resolved taken branches.
// - Sits beside the forwarding unit. Drives the PC, IF/ID, ID/EX and EX/MEM register enables.

---
 rtl/hazard_pkg.sv | 42 ++++
 rtl/hazard_mul_seq.sv | 43 ++++
 rtl/hazard_ctrl.sv | 145 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Optional feature macro used by hazard_ctrl: HAZARD_PERF_CNT_EN.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    MUL  = 2'd1,
    MEMW = 2'd2
  } hz_state_e;

  // Pipeline register controls, in order of the stages they touch.
  typedef struct packed {
    logic pc_stall;
    logic ifid_stall;
    logic ifid_flush;
    logic idex_stall;
    logic idex_flush;
    logic exmem_bubble;
    logic mem_freeze;
  } hz_ctrl_t;

  localparam hz_ctrl_t NO_STALL   = hz_ctrl_t'(7'b000_0000);
  // Data-memory wait: hold everything, inject nothing.
  localparam hz_ctrl_t MEM_FREEZE = hz_ctrl_t'(7'b110_1001);
  // Multiply occupying EX: hold front end, feed NOPs to MEM.
  localparam hz_ctrl_t MUL_HOLD   = hz_ctrl_t'(7'b110_1010);
  // Taken branch resolved in EX: squash the two younger instructions.
  localparam hz_ctrl_t BR_FLUSH   = hz_ctrl_t'(7'b001_0100);
  // Load-use: hold PC and IF/ID, insert one bubble into ID/EX.
  localparam hz_ctrl_t LU_STALL   = hz_ctrl_t'(7'b110_0100);

  // True when the ID instruction consumes the result of a load sitting in EX.
  function automatic logic load_use_hit(
    input logic [4:0] rs1, input logic rs1_used,
    input logic [4:0] rs2, input logic rs2_used,
    input logic [4:0] ex_rd, input logic ex_load
  );
    return ex_load && (ex_rd != 5'd0) &&
           ((rs1_used && (rs1 == ex_rd)) || (rs2_used && (rs2 == ex_rd)));
  endfunction

endpackage

// File: rtl/hazard_mul_seq.sv
// Multiplier occupancy sequencer: owns the remaining-cycle counter and
// produces the launch pulse, completion strobe and clock enable.
import hazard_pkg::*;

module hazard_mul_seq #(
  parameter int MUL_LAT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_launch,    // RUN-state multiply accepted this cycle
  input  logic i_in_mul,    // controller is in MUL
  input  logic i_freeze,    // data-memory wait, everything holds
  output logic o_mul_start,
  output logic o_mul_done,
  output logic o_mul_en,
  output logic o_mul_last   // final occupancy cycle of a multi-cycle multiply
);

  localparam logic       MULTI_CYCLE = (MUL_LAT > 1);
  localparam logic [3:0] LOAD_VAL    = 4'(MUL_LAT - 1);

  logic [3:0] r_mul_cnt;

  // Load on launch, count down while occupied, hold during a memory freeze.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mul_cnt <= 4'd0;
    end else if (!i_freeze) begin
      if (i_launch && MULTI_CYCLE) begin
        r_mul_cnt <= LOAD_VAL;
      end else if (i_in_mul && (r_mul_cnt != 4'd0)) begin
        r_mul_cnt <= r_mul_cnt - 4'd1;
      end
    end
  end

  assign o_mul_last  = i_in_mul && (r_mul_cnt == 4'd1);
  assign o_mul_start = i_launch;
  // A single-cycle multiplier finishes in the cycle it is launched.
  assign o_mul_done  = MULTI_CYCLE ? o_mul_last : i_launch;
  assign o_mul_en    = rst_n && !i_freeze;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage RV32 core: stalls, flushes
// and bubbles for load-use, multiply occupancy, data-memory wait and taken
// branches. Define HAZARD_PERF_CNT_EN to add saturating event counters.
import hazard_pkg::*;

module hazard_ctrl #(
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_rs1_used_i,
  input  logic             id_rs2_used_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             ex_mem_read_i,
  input  logic             ex_mul_i,
  input  logic             ex_branch_taken_i,
  input  logic             mem_access_i,
  input  logic             dmem_ready_i,
  output logic             pc_stall_o,
  output logic             ifid_stall_o,
  output logic             ifid_flush_o,
  output logic             idex_stall_o,
  output logic             idex_flush_o,
  output logic             exmem_bubble_o,
  output logic             mem_freeze_o,
  output logic             mul_start_o,
  output logic             mul_en_o,
`ifdef HAZARD_PERF_CNT_EN
  output logic             mul_done_o,
  output logic [CNT_W-1:0] loaduse_cnt_o,
  output logic [CNT_W-1:0] mul_stall_cnt_o,
  output logic [CNT_W-1:0] mem_stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
`else
  output logic             mul_done_o
`endif
);

  localparam logic MULTI_CYCLE = (MUL_LAT > 1);

  hz_state_e r_state;
  hz_state_e w_next_state;
  hz_ctrl_t  w_ctrl;
  logic      w_freeze;
  logic      w_load_use;
  logic      w_launch;
  logic      w_mul_start;
  logic      w_mul_done;
  logic      w_mul_en;
  logic      w_mul_last;

  assign w_freeze   = mem_access_i && !dmem_ready_i;
  assign w_load_use = load_use_hit(id_rs1_i, id_rs1_used_i, id_rs2_i, id_rs2_used_i,
                                   ex_rd_i, ex_mem_read_i);
  assign w_launch   = (r_state == RUN) && !w_freeze && ex_mul_i;

  hazard_mul_seq #(.MUL_LAT(MUL_LAT)) u_mul_seq (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_launch    (w_launch),
    .i_in_mul    (r_state == MUL),
    .i_freeze    (w_freeze),
    .o_mul_start (w_mul_start),
    .o_mul_done  (w_mul_done),
    .o_mul_en    (w_mul_en),
    .o_mul_last  (w_mul_last)
  );

  // State register; reset aborts any multiply or memory wait.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= RUN;
    else        r_state <= w_next_state;
  end

  // Next state and pipeline controls, priority: freeze, multiply, branch, load-use.
  always_comb begin
    w_ctrl       = NO_STALL;
    w_next_state = r_state;
    if (w_freeze) begin
      w_ctrl = MEM_FREEZE;
      if (r_state == RUN) w_next_state = MEMW;
    end else begin
      case (r_state)
        RUN: begin
          if (ex_mul_i && MULTI_CYCLE) begin
            w_ctrl       = MUL_HOLD;
            w_next_state = MUL;
          end else if (ex_branch_taken_i) begin
            w_ctrl = BR_FLUSH;
          end else if (w_load_use) begin
            w_ctrl = LU_STALL;
          end
        end
        MUL: begin
          if (w_mul_last) w_next_state = RUN;
          else            w_ctrl       = MUL_HOLD;
        end
        // Memory has answered; load-use is re-evaluated from RUN next cycle.
        MEMW:    w_next_state = RUN;
        default: w_next_state = RUN;
      endcase
    end
  end

  assign pc_stall_o     = rst_n && w_ctrl.pc_stall;
  assign ifid_stall_o   = rst_n && w_ctrl.ifid_stall;
  assign ifid_flush_o   = rst_n && w_ctrl.ifid_flush;
  assign idex_stall_o   = rst_n && w_ctrl.idex_stall;
  assign idex_flush_o   = rst_n && w_ctrl.idex_flush;
  assign exmem_bubble_o = rst_n && w_ctrl.exmem_bubble;
  assign mem_freeze_o   = rst_n && w_ctrl.mem_freeze;
  assign mul_start_o    = rst_n && w_mul_start;
  assign mul_en_o       = rst_n && w_mul_en;
  assign mul_done_o     = rst_n && w_mul_done;

`ifdef HAZARD_PERF_CNT_EN
  // Event order: [3] load-use, [2] multiply stall, [1] memory stall, [0] branch flush.
  logic [3:0] w_evt;
  assign w_evt = {w_ctrl.pc_stall && w_ctrl.idex_flush,
                  w_ctrl.exmem_bubble,
                  w_ctrl.mem_freeze,
                  w_ctrl.ifid_flush};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_perf
      logic [CNT_W-1:0] r_cnt;
      // Saturating event counter; sticks at all-ones.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         r_cnt <= '0;
        else if (w_evt[gi] && (r_cnt != '1)) r_cnt <= r_cnt + 1'b1;
      end
    end
  endgenerate

  assign loaduse_cnt_o   = g_perf[3].r_cnt;
  assign mul_stall_cnt_o = g_perf[2].r_cnt;
  assign mem_stall_cnt_o = g_perf[1].r_cnt;
  assign flush_cnt_o     = g_perf[0].r_cnt;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl (MUL_LAT = 4).
// Control vector bit order: pc_stall ifid_stall ifid_flush idex_stall
// idex_flush exmem_bubble mem_freeze mul_start mul_en mul_done.
`timescale 1ns/1ps
import hazard_pkg::*;

module tb_hazard_ctrl;

`ifdef HAZARD_PERF_CNT_EN
  localparam int TB_CNT_W = 3;
`else
  localparam int TB_CNT_W = 32;
`endif

  localparam logic [9:0] ZERO   = 10'b00000_00000;
  localparam logic [9:0] IDLE   = 10'b00000_00010;
  localparam logic [9:0] LU     = 10'b11001_00010;
  localparam logic [9:0] BRF    = 10'b00101_00010;
  localparam logic [9:0] MSTART = 10'b11010_10110;
  localparam logic [9:0] MBUSY  = 10'b11010_10010;
  localparam logic [9:0] MDONE  = 10'b00000_00011;
  localparam logic [9:0] FRZ    = 10'b11010_01000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_rs1_used, id_rs2_used, ex_mem_read, ex_mul, ex_br;
  logic       mem_access, dmem_ready;
  logic       pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush;
  logic       exmem_bubble, mem_freeze, mul_start, mul_en, mul_done;
  logic [9:0] ctrl_vec;
`ifdef HAZARD_PERF_CNT_EN
  logic [TB_CNT_W-1:0] lu_cnt, mul_cnt_o, mem_cnt, fl_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MUL_LAT(4), .CNT_W(TB_CNT_W)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .id_rs1_i          (id_rs1),
    .id_rs2_i          (id_rs2),
    .id_rs1_used_i     (id_rs1_used),
    .id_rs2_used_i     (id_rs2_used),
    .ex_rd_i           (ex_rd),
    .ex_mem_read_i     (ex_mem_read),
    .ex_mul_i          (ex_mul),
    .ex_branch_taken_i (ex_br),
    .mem_access_i      (mem_access),
    .dmem_ready_i      (dmem_ready),
    .pc_stall_o        (pc_stall),
    .ifid_stall_o      (ifid_stall),
    .ifid_flush_o      (ifid_flush),
    .idex_stall_o      (idex_stall),
    .idex_flush_o      (idex_flush),
    .exmem_bubble_o    (exmem_bubble),
    .mem_freeze_o      (mem_freeze),
    .mul_start_o       (mul_start),
    .mul_en_o          (mul_en),
`ifdef HAZARD_PERF_CNT_EN
    .mul_done_o        (mul_done),
    .loaduse_cnt_o     (lu_cnt),
    .mul_stall_cnt_o   (mul_cnt_o),
    .mem_stall_cnt_o   (mem_cnt),
    .flush_cnt_o       (fl_cnt)
`else
    .mul_done_o        (mul_done)
`endif
  );

  assign ctrl_vec = {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
                     exmem_bubble, mem_freeze, mul_start, mul_en, mul_done};

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end else begin
      $display("ok   %s: %0h", tag, act);
    end
  endtask

  // Settle combinational outputs, compare, then advance to just past the next edge.
  task automatic tick_check(input string tag, input logic [9:0] exp);
    #2;
    check_eq(tag, 32'(ctrl_vec), 32'(exp));
    @(posedge clk);
    #1;
  endtask

  task automatic clr_inputs();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_rs1_used = 1'b0; id_rs2_used = 1'b0;
    ex_mem_read = 1'b0; ex_mul = 1'b0; ex_br = 1'b0;
    mem_access = 1'b0; dmem_ready = 1'b1;
  endtask

  // lw x5 in EX, add x6,x5,x1 in ID
  task automatic set_load_use();
    ex_mem_read = 1'b1; ex_rd = 5'd5;
    id_rs1 = 5'd5; id_rs1_used = 1'b1;
    id_rs2 = 5'd1; id_rs2_used = 1'b1;
  endtask

  initial begin
    clr_inputs();
    rst_n = 1'b0;
    ex_mul = 1'b1;   // must be ignored while in reset
    #3;
    check_eq("reset_outputs", 32'(ctrl_vec), 32'(ZERO));
    @(posedge clk); #1;
    check_eq("reset_state", 32'(dut.r_state), 32'(RUN));
    ex_mul = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    tick_check("idle", IDLE);

    // Load-use on rs1, then the load leaves EX.
    set_load_use();
    tick_check("lu_rs1", LU);
    clr_inputs();
    tick_check("lu_after", IDLE);
    // Load to x0 never creates a hazard.
    ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_rs1_used = 1'b1;
    tick_check("lu_x0", IDLE);
    // rs2 match but rs2 not read.
    clr_inputs();
    ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_rs2_used = 1'b0;
    tick_check("lu_rs2_unused", IDLE);
    id_rs2_used = 1'b1;
    tick_check("lu_rs2", LU);
    // Non-load producer: forwarding handles it.
    ex_mem_read = 1'b0;
    tick_check("no_load", IDLE);

    // Branch alone, then branch together with load-use.
    clr_inputs();
    ex_br = 1'b1;
    tick_check("branch", BRF);
    set_load_use();
    tick_check("branch_over_lu", BRF);
    clr_inputs();

    // Plain 4-cycle multiply.
    ex_mul = 1'b1;
    tick_check("mul_c1_start", MSTART);
    tick_check("mul_c2", MBUSY);
    tick_check("mul_c3", MBUSY);
    tick_check("mul_c4_done", MDONE);
    ex_mul = 1'b0;
    check_eq("mul_c5_state", 32'(dut.r_state), 32'(RUN));
    tick_check("mul_c5_idle", IDLE);

    // Multiply with a 2-cycle memory wait at cnt=2.
    ex_mul = 1'b1;
    tick_check("mw_c1_start", MSTART);
    tick_check("mw_c2", MBUSY);
    mem_access = 1'b1; dmem_ready = 1'b0;
    #2 check_eq("mw_cnt_hold_a", 32'(dut.u_mul_seq.r_mul_cnt), 32'd2);
    tick_check("mw_freeze_a", FRZ);
    check_eq("mw_state_mul", 32'(dut.r_state), 32'(MUL));
    tick_check("mw_freeze_b", FRZ);
    check_eq("mw_cnt_hold_b", 32'(dut.u_mul_seq.r_mul_cnt), 32'd2);
    dmem_ready = 1'b1;
    tick_check("mw_resume", MBUSY);
    mem_access = 1'b0;
    tick_check("mw_done", MDONE);
    clr_inputs();
    tick_check("mw_idle", IDLE);

    // Memory wait from RUN overrides a pending load-use.
    set_load_use();
    mem_access = 1'b1; dmem_ready = 1'b0;
    tick_check("memw_enter", FRZ);
    check_eq("memw_state", 32'(dut.r_state), 32'(MEMW));
    tick_check("memw_hold", FRZ);
    dmem_ready = 1'b1;
    tick_check("memw_exit_nolu", IDLE);
    mem_access = 1'b0;
    tick_check("memw_lu_reeval", LU);
    clr_inputs();

    // Reset during MUL at cnt=2, then a fresh full-length multiply.
    ex_mul = 1'b1;
    tick_check("rm_start", MSTART);
    tick_check("rm_c2", MBUSY);
    rst_n = 1'b0;
    #1;
    check_eq("rm_reset_out", 32'(ctrl_vec), 32'(ZERO));
    @(posedge clk); #1;
    check_eq("rm_reset_state", 32'(dut.r_state), 32'(RUN));
    ex_mul = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    tick_check("rm_idle", IDLE);
    ex_mul = 1'b1;
    tick_check("rm2_start", MSTART);
    tick_check("rm2_c2", MBUSY);
    tick_check("rm2_c3", MBUSY);
    tick_check("rm2_done", MDONE);
    clr_inputs();
    tick_check("rm2_idle", IDLE);

`ifdef HAZARD_PERF_CNT_EN
    // Fresh counters, 3 load-use events, then saturate the 3-bit counter.
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      set_load_use();
      tick_check("pc_lu", LU);
      clr_inputs();
      tick_check("pc_gap", IDLE);
    end
    check_eq("perf_lu3", 32'(lu_cnt), 32'd3);
    check_eq("perf_mul0", 32'(mul_cnt_o), 32'd0);
    for (int i = 0; i < 6; i++) begin
      set_load_use();
      tick_check("pc_lu_sat", LU);
    end
    clr_inputs();
    check_eq("perf_lu_sat", 32'(lu_cnt), 32'd7);
    check_eq("perf_flush0", 32'(fl_cnt), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
